// File: rtl/telephony_pkg.sv
// Shared encodings for the telephony session/transport path:
// command bus codes, control opcodes and scheduler FSM states.
package telephony_pkg;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_CTRL  = 2'b01;
    localparam logic [1:0] CMD_AUDIO = 2'b10;

    localparam logic [7:0] OP_CALL      = 8'h01;
    localparam logic [7:0] OP_ANSWER    = 8'h02;
    localparam logic [7:0] OP_VOICEMAIL = 8'h03;
    localparam logic [7:0] OP_HANGUP    = 8'h05;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;

endpackage

// File: rtl/ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO for control packets;
// the head word is visible on dout whenever the FIFO is non-empty.
module ctrl_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so push-while-full succeeds then.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Owns the outgoing packet path: queues control packets, holds one audio
// word, and issues one packet per two cycles with bounded audio starvation.
module tx_scheduler
    import telephony_pkg::*;
#(
    parameter int CTRL_DEPTH = 4,
    parameter int STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sess_cmd,
    input  logic [15:0] sess_data,
    input  logic        transport_busy,
    output logic [1:0]  tx_cmd,
    output logic [15:0] tx_data,
    output logic        sched_busy,
    output logic [7:0]  ctrl_drops,
    output logic [7:0]  audio_drops
);

    localparam int CW = $clog2(CTRL_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [0:0]    state;
    logic          audio_full;
    logic [15:0]   audio_data;
    logic [SW-1:0] starve_cnt;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [15:0]   fifo_dout;

    logic ctrl_push;
    logic issue;
    logic pick_audio;
    logic audio_issue;
    logic ctrl_issue;

    assign ctrl_push   = (sess_cmd == CMD_CTRL);
    assign issue       = (state == ST_IDLE) && !transport_busy && (!fifo_empty || audio_full);
    // Audio wins when it is the only thing pending or control has starved it long enough.
    assign pick_audio  = audio_full && (fifo_empty || starve_cnt == SW'(STARVE_MAX));
    assign audio_issue = issue && pick_audio;
    assign ctrl_issue  = issue && !pick_audio;
    assign sched_busy  = audio_full || (fifo_count >= CW'(CTRL_DEPTH - 1));

    ctrl_fifo #(
        .DEPTH (CTRL_DEPTH),
        .WIDTH (16)
    ) u_ctrl_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ctrl_push),
        .din   (sess_data),
        .pop   (ctrl_issue),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            audio_full  <= 1'b0;
            audio_data  <= '0;
            starve_cnt  <= '0;
            tx_cmd      <= CMD_NONE;
            tx_data     <= '0;
            ctrl_drops  <= '0;
            audio_drops <= '0;
        end else begin
            tx_cmd  <= CMD_NONE;
            tx_data <= '0;

            case (state)
                ST_IDLE: if (issue) state <= ST_GAP;
                default: state <= ST_IDLE;
            endcase

            if (issue) begin
                tx_cmd  <= pick_audio ? CMD_AUDIO : CMD_CTRL;
                tx_data <= pick_audio ? audio_data : fifo_dout;
            end

            if (sess_cmd == CMD_AUDIO) begin
                audio_data <= sess_data;
                audio_full <= 1'b1;
                if (audio_full && !audio_issue && audio_drops != '1) begin
                    audio_drops <= audio_drops + 1'b1;
                end
            end else if (audio_issue) begin
                audio_full <= 1'b0;
            end

            if (ctrl_push && fifo_full && !ctrl_issue && ctrl_drops != '1) begin
                ctrl_drops <= ctrl_drops + 1'b1;
            end

            if (!audio_full || audio_issue) begin
                starve_cnt <= '0;
            end else if (ctrl_issue) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed-vector bench for tx_scheduler with CTRL_DEPTH=4, STARVE_MAX=2.
module tb_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sess_cmd;
    logic [15:0] sess_data;
    logic        transport_busy;
    logic [1:0]  tx_cmd;
    logic [15:0] tx_data;
    logic        sched_busy;
    logic [7:0]  ctrl_drops;
    logic [7:0]  audio_drops;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    tx_scheduler #(
        .CTRL_DEPTH (4),
        .STARVE_MAX (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sess_cmd       (sess_cmd),
        .sess_data      (sess_data),
        .transport_busy (transport_busy),
        .tx_cmd         (tx_cmd),
        .tx_data        (tx_data),
        .sched_busy     (sched_busy),
        .ctrl_drops     (ctrl_drops),
        .audio_drops    (audio_drops)
    );

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        sess_cmd       = 2'b00;
        sess_data      = '0;
        transport_busy = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic send(input logic [1:0] cmd, input logic [15:0] data);
        sess_cmd  = cmd;
        sess_data = data;
        step();
        sess_cmd  = 2'b00;
        sess_data = '0;
    endtask

    // Step until an issue is seen; n = cycles stepped, cmd 00 if budget expired.
    task automatic wait_issue(output logic [1:0] cmd, output logic [15:0] data, output int n);
        cmd  = 2'b00;
        data = '0;
        n    = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (tx_cmd !== 2'b00) begin
                cmd  = tx_cmd;
                data = tx_data;
                return;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({tx_cmd, tx_data, sched_busy, ctrl_drops, audio_drops} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got cmd=%b data=%h busy=%b cd=%h ad=%h, want all zero",
                     tx_cmd, tx_data, sched_busy, ctrl_drops, audio_drops);
        end
    endtask

    task automatic test_single_ctrl();
        apply_reset();
        send(2'b01, 16'h2A01);
        vectors++;
        if (tx_cmd !== 2'b00) begin
            errors++;
            $display("FAIL single_t1: tx_cmd=%b, want 00", tx_cmd);
        end
        step();
        vectors++;
        if (tx_cmd !== 2'b01 || tx_data !== 16'h2A01) begin
            errors++;
            $display("FAIL single_t2: tx=%b/%h, want 01/2a01", tx_cmd, tx_data);
        end
        step();
        vectors++;
        if (tx_cmd !== 2'b00) begin
            errors++;
            $display("FAIL single_pulse: tx_cmd=%b, want 00", tx_cmd);
        end
    endtask

    task automatic test_burst_overflow();
        logic [1:0]  c;
        logic [15:0] d;
        int          n;
        logic [15:0] w;
        apply_reset();
        transport_busy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            w = {i[7:0], 8'h01};
            send(2'b01, w);
            if (i == 2) begin
                vectors++;
                if (sched_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_busy_2: sched_busy=%b, want 0", sched_busy);
                end
            end
            if (i == 3) begin
                vectors++;
                if (sched_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_busy_3: sched_busy=%b, want 1", sched_busy);
                end
            end
        end
        vectors++;
        if (ctrl_drops !== 8'd2) begin
            errors++;
            $display("FAIL burst_drops: ctrl_drops=%0d, want 2", ctrl_drops);
        end
        transport_busy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            w = {i[7:0], 8'h01};
            wait_issue(c, d, n);
            vectors++;
            if (c !== 2'b01 || d !== w || (i > 1 && n != 2)) begin
                errors++;
                $display("FAIL burst_issue_%0d: got %b/%h after %0d, want 01/%h after 2",
                         i, c, d, n, w);
            end
        end
        wait_issue(c, d, n);
        vectors++;
        if (c !== 2'b00 || sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_extra: got %b/%h busy=%b, want no issue busy=0", c, d, sched_busy);
        end
    endtask

    task automatic test_starvation();
        logic [1:0]  c;
        logic [15:0] d;
        int          n;
        logic [1:0]  exp_c [5] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
        logic [15:0] exp_d [5] = '{16'h0102, 16'h0202, 16'hBEEF, 16'h0302, 16'h0402};
        apply_reset();
        transport_busy = 1'b1;
        send(2'b01, 16'h0102);
        send(2'b01, 16'h0202);
        send(2'b01, 16'h0302);
        send(2'b01, 16'h0402);
        send(2'b10, 16'hBEEF);
        vectors++;
        if (ctrl_drops !== 8'd0 || audio_drops !== 8'd0 || sched_busy !== 1'b1) begin
            errors++;
            $display("FAIL starve_load: cd=%0d ad=%0d busy=%b, want 0 0 1", ctrl_drops, audio_drops, sched_busy);
        end
        transport_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_issue(c, d, n);
            vectors++;
            if (c !== exp_c[i] || d !== exp_d[i]) begin
                errors++;
                $display("FAIL starve_issue_%0d: got %b/%h, want %b/%h", i, c, d, exp_c[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_audio_overwrite();
        logic [1:0]  c;
        logic [15:0] d;
        int          n;
        apply_reset();
        transport_busy = 1'b1;
        send(2'b10, 16'h1111);
        send(2'b10, 16'h2222);
        vectors++;
        if (audio_drops !== 8'd1) begin
            errors++;
            $display("FAIL audio_drops: audio_drops=%0d, want 1", audio_drops);
        end
        transport_busy = 1'b0;
        wait_issue(c, d, n);
        vectors++;
        if (c !== 2'b10 || d !== 16'h2222) begin
            errors++;
            $display("FAIL audio_issue: got %b/%h, want 10/2222", c, d);
        end
        wait_issue(c, d, n);
        vectors++;
        if (c !== 2'b00) begin
            errors++;
            $display("FAIL audio_extra: got %b/%h, want no issue", c, d);
        end
    endtask

    task automatic test_ignored_cmd();
        logic [1:0]  c;
        logic [15:0] d;
        int          n;
        apply_reset();
        send(2'b11, 16'hDEAD);
        wait_issue(c, d, n);
        vectors++;
        if (c !== 2'b00 || ctrl_drops !== 8'd0 || audio_drops !== 8'd0) begin
            errors++;
            $display("FAIL ignored_cmd: got %b/%h cd=%0d ad=%0d, want none", c, d, ctrl_drops, audio_drops);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        transport_busy = 1'b1;
        for (int i = 0; i < 4 + 260; i++) begin
            send(2'b01, 16'h0505);
        end
        vectors++;
        if (ctrl_drops !== 8'hFF) begin
            errors++;
            $display("FAIL ctrl_saturate: ctrl_drops=%h, want ff", ctrl_drops);
        end
    endtask

    task automatic test_reset_mid_queue();
        apply_reset();
        transport_busy = 1'b1;
        send(2'b01, 16'h0111);
        send(2'b01, 16'h0222);
        send(2'b01, 16'h0333);
        send(2'b10, 16'h4444);
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if ({tx_cmd, tx_data, sched_busy, ctrl_drops, audio_drops} !== 35'd0) begin
            errors++;
            $display("FAIL midreset_outputs: cmd=%b data=%h busy=%b cd=%h ad=%h, want all zero",
                     tx_cmd, tx_data, sched_busy, ctrl_drops, audio_drops);
        end
        transport_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (tx_cmd !== 2'b00 || sched_busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet_%0d: tx_cmd=%b busy=%b, want 00 0", i, tx_cmd, sched_busy);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        sess_cmd       = 2'b00;
        sess_data      = '0;
        transport_busy = 1'b0;
        test_reset();
        test_single_ctrl();
        test_burst_overflow();
        test_starvation();
        test_audio_overwrite();
        test_ignored_cmd();
        test_saturation();
        test_reset_mid_queue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
